// File: rtl/mux_arb_n_pkg.sv
// mux_pkg: shared definitions for the mux_arb_n slice.
//   MODE_SELECT / MODE_RR : encodings of the mode input.
//   idx_w(n)              : index width for n channels, never below 1.
package mux_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // $clog2(1) is 0, which would give a zero-width select bus.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: handshake bundle for mux_arb_n.
//   mode/sel          : channel choice (select index or round-robin)
//   in_data/in_valid  : N request channels, channel i at [i*WIDTH +: WIDTH]
//   in_ready          : per-channel accept, one-hot or zero
//   out_*             : registered result with valid/ready
// master drives the requests and consumes the result; slave is the mux.
interface mux_arb_n_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8
);
    localparam int SELW = mux_pkg::idx_w(N);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_src;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux_arb_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       : request vector
//   ptr       : highest-priority index (must be < N)
//   gnt_valid : some request found
//   gnt_idx   : first requesting index at or above ptr, wrapping N-1 -> 0
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int SELW = mux_pkg::idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);
    always_comb begin
        int j;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap so non-power-of-two N works
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(j);
            end
        end
    end
endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input registered mux with explicit select or round-robin
// arbitration and one output register stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mux_arb_n_if.slave (mode, sel, in_*, out_*)
module mux_arb_n
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 8,
    localparam int SELW  = idx_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    mux_arb_n_if.slave        bus
);
    logic [SELW-1:0] rr_ptr;
    logic            rr_v;
    logic [SELW-1:0] rr_g;
    logic            gv;
    logic [SELW-1:0] g;
    logic            can_load;
    logic            xfer;

    rr_arbiter #(.N(N)) u_rr (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_v),
        .gnt_idx   (rr_g)
    );

    assign can_load = !bus.out_valid || bus.out_ready;

    always_comb begin
        gv           = 1'b0;
        g            = '0;
        bus.in_ready = '0;
        if (bus.mode == MODE_RR) begin
            gv = rr_v;
            g  = rr_g;
        end else if (int'(bus.sel) < N) begin
            // out-of-range sel never grants
            gv = bus.in_valid[bus.sel];
            g  = bus.sel;
        end
        if (gv) bus.in_ready[g] = can_load;
    end

    assign xfer = gv && can_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            rr_ptr        <= '0;
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[int'(g)*WIDTH +: WIDTH];
                bus.out_src   <= g;
                if (bus.mode == MODE_RR)
                    rr_ptr <= (g == SELW'(N-1)) ? '0 : g + 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
